pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MA/WB).
- Tracks destination registers of in-flight instructions in shadow EX/MA/WB slots.
- Produces registered forwarding selects consumed by the EX datapath, plus the load-use interlock.
- Owns the global stall/rst_pipe generation, including a debug halt/step FSM.

Parameters:
RADR_W, 5, register address width
START_HALTED, 0, 1 = FSM leaves reset in HALTED instead of RUN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rs1_adr_id  in  RADR_W  rs1 address of instruction in ID
rs2_adr_id  in  RADR_W  rs2 address of instruction in ID
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rd_adr_id  in  RADR_W  rd address of ID instruction
wbk_rd_reg_id  in  1  ID instruction writes rd
cmd_ld_id  in  1  ID instruction is a load
jmp_purge_ex  in  1  taken jump/ecall in EX; kills the ID instruction
jmp_purge_ma  in  1  kills the EX instruction's writeback
mem_wait  in  1  external memory not ready
dbg_halt  in  1  pulse: halt request
dbg_step  in  1  pulse: execute one cycle while halted
dbg_resume  in  1  pulse: return to RUN
dbg_restart  in  1  pulse: flush pipeline
hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex  out  1 each  rs1 forwarding selects for EX
hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex  out  1 each  rs2 forwarding selects for EX
stall  out  1  global pipeline freeze
stall_id  out  1  hold IF/ID, inject bubble into EX (load-use)
rst_pipe  out  1  synchronous pipeline flush
halted  out  1  FSM in HALTED

Behaviour:
Reset values:
- All hit_* = 0; nohit_* = 1; stall_id = 0; rst_pipe = 0.
- Shadow valids = 0.
- FSM = RUN with stall = 0 and halted = 0; if START_HALTED, FSM = HALTED with stall = 1 and halted = 1.

Shadow slots:
- Each slot (EX, MA, WB) holds {vld, rd, ld}; advances only when ~stall.
- ID->EX: vld = wbk_rd_reg_id & ~jmp_purge_ex & ~stall_id & (rd_adr_id != 0); ld = cmd_ld_id.
- EX->MA: vld = vld_ex & ~jmp_purge_ma.
- MA->WB: plain copy.

Hit computation (combinational in ID, registered into *_ex on ~stall):
- mEX = rsN_used & vld_ex & rd_ex == rsN; mMA and mWB likewise.
- Priority EX > MA > WB: idex = mEX; idma = ~mEX & mMA; idwb = ~mEX & ~mMA & mWB; nohit = ~(mEX | mMA | mWB).
- rsN == 0 never hits.
- When stall_id or jmp_purge_ex is set, the registered value is a bubble: all hits 0, nohit 1.
- Exactly one of {idex, idma, idwb, nohit} is high per operand, every cycle.

Load-use interlock:
- stall_id = (mEX_rs1 | mEX_rs2) & ld_ex & vld_ex & ~stall & ~jmp_purge_ex; combinational.
- Asserted for exactly 1 cycle; the next cycle re-evaluates with the load in MA, giving idma.
- Back-to-back load then store-use gives one bubble only.

stall = mem_wait | (FSM != RUN && !(FSM == STEP)).

FSM states RUN, HALTED, STEP:
- RUN: dbg_halt -> HALTED (stall from next cycle).
- HALTED: dbg_step -> STEP; dbg_resume -> RUN; dbg_step and dbg_resume in the same cycle: resume wins.
- STEP: one cycle with stall = mem_wait, then HALTED. If mem_wait is high in STEP, remain in STEP until a non-waiting cycle completes.

dbg_restart:
- Any state; rst_pipe = 1 for the next cycle (registered).
- Clears shadow valids and hit registers to the bubble value; the FSM state is unchanged.
- Highest priority over all other updates in the same cycle.

Simultaneous events:
- mem_wait freezes shadow slots and hit registers even during stall_id evaluation; stall_id is forced 0 while stall.
- jmp_purge_ex suppresses stall_id.

Decomposition:
- Shared package: FSM state encoding (RUN = 2'd0, HALTED = 2'd1, STEP = 2'd2), RADR_W default, and the bubble constant for the hit vector {idex, idma, idwb, nohit} = 4'b0001.
- One sub-module, fwd_match: per-operand 3-slot compare and priority encode, instantiated twice (rs1, rs2).

Test Plan:
- Dependency distance: addi x5 then add x6,x5,x5 at distances 1, 2 and 3 -> hit_rs1/rs2_idex_ex, then _idma_ex, then _idwb_ex high, the rest 0; distance 4 -> nohit = 1.
- Load-use: lw x7 then add x8,x7,x0 -> stall_id = 1 for exactly one cycle, EX gets a bubble (nohit = 1), then hit_rs1_idma_ex = 1.
- x0 and kills: writes to x0, or a jmp_purge_ex-killed producer, followed by a consumer of that register -> nohit = 1, stall_id = 0.
- mem_wait: high 3 cycles mid-sequence -> stall = 1, all hit outputs and shadow slots frozen; the correct hit appears after release.
- Debug sequencing: dbg_halt -> halted = 1 next cycle; dbg_step -> stall = 0 for exactly 1 cycle; dbg_step + dbg_resume in the same cycle -> RUN.
- Restart and reset: dbg_restart -> rst_pipe = 1 for one cycle and all nohit = 1. rst_n asserted mid-stall_id -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned RADR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } dbg_state_e;

  // Per-operand forwarding select; exactly one field is set at any time.
  typedef struct packed {
    logic idex;
    logic idma;
    logic idwb;
    logic nohit;
  } hit_vec_t;

  localparam hit_vec_t HIT_BUBBLE = 4'b0001;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// One source operand compared against the EX/MA/WB shadow slots, priority EX > MA > WB.
module pipe_hazard_ctrl_fwd_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RADR_W = RADR_W_DEF
) (
  input  logic [RADR_W-1:0] rs_adr,
  input  logic              rs_used,
  input  logic              vld_ex,
  input  logic [RADR_W-1:0] rd_ex,
  input  logic              vld_ma,
  input  logic [RADR_W-1:0] rd_ma,
  input  logic              vld_wb,
  input  logic [RADR_W-1:0] rd_wb,
  output hit_vec_t          hit_c,
  output logic              m_ex_c
);

  logic rs_live;
  logic m_ma;
  logic m_wb;

  // x0 is hard-wired zero and never forwarded.
  assign rs_live = rs_used & (rs_adr != '0);
  assign m_ex_c  = rs_live & vld_ex & (rd_ex == rs_adr);
  assign m_ma    = rs_live & vld_ma & (rd_ma == rs_adr);
  assign m_wb    = rs_live & vld_wb & (rd_wb == rs_adr);

  always_comb begin
    hit_c       = HIT_BUBBLE;
    hit_c.idex  = m_ex_c;
    hit_c.idma  = ~m_ex_c & m_ma;
    hit_c.idwb  = ~m_ex_c & ~m_ma & m_wb;
    hit_c.nohit = ~(m_ex_c | m_ma | m_wb);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: shadow rd slots, registered forwarding selects, load-use
// interlock, global stall and debug halt/step sequencing.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RADR_W       = RADR_W_DEF,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RADR_W-1:0] rs1_adr_id,
  input  logic [RADR_W-1:0] rs2_adr_id,
  input  logic              rs1_used_id,
  input  logic              rs2_used_id,
  input  logic [RADR_W-1:0] rd_adr_id,
  input  logic              wbk_rd_reg_id,
  input  logic              cmd_ld_id,
  input  logic              jmp_purge_ex,
  input  logic              jmp_purge_ma,
  input  logic              mem_wait,
  input  logic              dbg_halt,
  input  logic              dbg_step,
  input  logic              dbg_resume,
  input  logic              dbg_restart,
  output logic              hit_rs1_idex_ex,
  output logic              hit_rs1_idma_ex,
  output logic              hit_rs1_idwb_ex,
  output logic              nohit_rs1_ex,
  output logic              hit_rs2_idex_ex,
  output logic              hit_rs2_idma_ex,
  output logic              hit_rs2_idwb_ex,
  output logic              nohit_rs2_ex,
  output logic              stall,
  output logic              stall_id,
  output logic              rst_pipe,
  output logic              halted
);

  dbg_state_e        state_q, state_d;
  logic              vld_ex, vld_ma, vld_wb, ld_ex;
  logic [RADR_W-1:0] rd_ex, rd_ma, rd_wb;
  hit_vec_t          hit1_c, hit2_c, hit1_q, hit2_q;
  logic              m_ex1_c, m_ex2_c;
  logic              rst_pipe_q;

  pipe_hazard_ctrl_fwd_match #(.RADR_W(RADR_W)) u_fwd_match_rs1 (
    .rs_adr(rs1_adr_id), .rs_used(rs1_used_id),
    .vld_ex(vld_ex), .rd_ex(rd_ex), .vld_ma(vld_ma), .rd_ma(rd_ma),
    .vld_wb(vld_wb), .rd_wb(rd_wb), .hit_c(hit1_c), .m_ex_c(m_ex1_c)
  );

  pipe_hazard_ctrl_fwd_match #(.RADR_W(RADR_W)) u_fwd_match_rs2 (
    .rs_adr(rs2_adr_id), .rs_used(rs2_used_id),
    .vld_ex(vld_ex), .rd_ex(rd_ex), .vld_ma(vld_ma), .rd_ma(rd_ma),
    .vld_wb(vld_wb), .rd_wb(rd_wb), .hit_c(hit2_c), .m_ex_c(m_ex2_c)
  );

  assign stall    = mem_wait | ((state_q != ST_RUN) & (state_q != ST_STEP));
  assign stall_id = (m_ex1_c | m_ex2_c) & ld_ex & vld_ex & ~stall & ~jmp_purge_ex;

  // Debug sequencing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= START_HALTED ? ST_HALTED : ST_RUN;
    else        state_q <= state_d;
  end

  // Resume beats step when both arrive while halted; a step lasts until a non-waiting cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (dbg_halt) state_d = ST_HALTED;
      ST_HALTED: begin
        if (dbg_resume)    state_d = ST_RUN;
        else if (dbg_step) state_d = ST_STEP;
      end
      ST_STEP:   if (!mem_wait) state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Shadow slots and forwarding selects; restart overrides everything, stall freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_ex <= 1'b0;
      vld_ma <= 1'b0;
      vld_wb <= 1'b0;
      ld_ex  <= 1'b0;
      rd_ex  <= '0;
      rd_ma  <= '0;
      rd_wb  <= '0;
      hit1_q <= HIT_BUBBLE;
      hit2_q <= HIT_BUBBLE;
    end else if (dbg_restart) begin
      vld_ex <= 1'b0;
      vld_ma <= 1'b0;
      vld_wb <= 1'b0;
      hit1_q <= HIT_BUBBLE;
      hit2_q <= HIT_BUBBLE;
    end else if (!stall) begin
      vld_ex <= wbk_rd_reg_id & ~jmp_purge_ex & ~stall_id & (rd_adr_id != '0);
      rd_ex  <= rd_adr_id;
      ld_ex  <= cmd_ld_id;
      vld_ma <= vld_ex & ~jmp_purge_ma;
      rd_ma  <= rd_ex;
      vld_wb <= vld_ma;
      rd_wb  <= rd_ma;
      hit1_q <= (stall_id | jmp_purge_ex) ? HIT_BUBBLE : hit1_c;
      hit2_q <= (stall_id | jmp_purge_ex) ? HIT_BUBBLE : hit2_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe_q <= 1'b0;
    else        rst_pipe_q <= dbg_restart;
  end

  assign hit_rs1_idex_ex = hit1_q.idex;
  assign hit_rs1_idma_ex = hit1_q.idma;
  assign hit_rs1_idwb_ex = hit1_q.idwb;
  assign nohit_rs1_ex    = hit1_q.nohit;
  assign hit_rs2_idex_ex = hit2_q.idex;
  assign hit_rs2_idma_ex = hit2_q.idma;
  assign hit_rs2_idwb_ex = hit2_q.idwb;
  assign nohit_rs2_ex    = hit2_q.nohit;
  assign rst_pipe        = rst_pipe_q;
  assign halted          = (state_q == ST_HALTED);

endmodule
